// File: rtl/half_subtractor.sv
// Registered, lane-parallel half subtractor with a valid qualifier,
// OR-reduced borrow flag and a saturating borrow-event counter.
module half_subtractor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] borrow,
    output logic             out_valid,
    output logic             any_borrow,
    output logic [CNT_W-1:0] borrow_cnt
);

    logic [WIDTH-1:0] y_next;
    logic [WIDTH-1:0] borrow_next;
    logic             any_next;
    logic             cnt_sat;

    logic [WIDTH-1:0] y_reg;
    logic [WIDTH-1:0] borrow_reg;
    logic             out_valid_reg;
    logic             any_borrow_reg;
    logic [CNT_W-1:0] borrow_cnt_reg;

    // Each lane is an isolated 1-bit half subtractor; nothing ripples across lanes.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign y_next[gi]      = a[gi] ^ b[gi];
            assign borrow_next[gi] = ~a[gi] & b[gi];
        end
    endgenerate

    assign any_next = |borrow_next;
    assign cnt_sat  = &borrow_cnt_reg;

    // Data registers load only on valid input so idle (possibly X) inputs are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg          <= '0;
            borrow_reg     <= '0;
            any_borrow_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                y_reg          <= y_next;
                borrow_reg     <= borrow_next;
                any_borrow_reg <= any_next;
            end
        end
    end

    // Clear wins over a simultaneous borrow event; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            borrow_cnt_reg <= '0;
        end else if (cnt_clr) begin
            borrow_cnt_reg <= '0;
        end else if (in_valid && any_next && !cnt_sat) begin
            borrow_cnt_reg <= borrow_cnt_reg + 1'b1;
        end
    end

    assign y          = y_reg;
    assign borrow     = borrow_reg;
    assign out_valid  = out_valid_reg;
    assign any_borrow = any_borrow_reg;
    assign borrow_cnt = borrow_cnt_reg;

endmodule

// File: tb/tb_half_subtractor.sv
// Bench for half_subtractor: truth-table vectors, directed corner cases and
// random traffic on a 1-lane and a 4-lane (2-bit counter) instance.
module tb_half_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a1, b1, v1, c1;
    logic        y1, bo1, ov1, any1;
    logic [15:0] cnt1;

    logic [3:0]  a4, b4;
    logic        v4, c4;
    logic [3:0]  y4, bo4;
    logic        ov4, any4;
    logic [1:0]  cnt4;

    half_subtractor #(.WIDTH(1), .CNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1), .cnt_clr(c1),
        .y(y1), .borrow(bo1), .out_valid(ov1), .any_borrow(any1), .borrow_cnt(cnt1)
    );

    half_subtractor #(.WIDTH(4), .CNT_W(2)) u4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(v4), .cnt_clr(c4),
        .y(y4), .borrow(bo4), .out_valid(ov4), .any_borrow(any4), .borrow_cnt(cnt4)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: arithmetic view of a - b per lane.
    int m_y1, m_b1, m_ov1, m_any1, m_cnt1;
    int m_y4, m_b4, m_ov4, m_any4, m_cnt4;

    typedef struct {
        logic a;
        logic b;
        logic y;
        logic bo;
    } tt_vec_t;

    tt_vec_t tt [4];

    function automatic void model_clear();
        m_y1 = 0; m_b1 = 0; m_ov1 = 0; m_any1 = 0; m_cnt1 = 0;
        m_y4 = 0; m_b4 = 0; m_ov4 = 0; m_any4 = 0; m_cnt4 = 0;
    endfunction

    function automatic void model_edge();
        int d, bsum;
        bit ev;
        ev = 1'b0;
        if (v1) begin
            d      = int'(a1) - int'(b1);
            m_y1   = (d != 0) ? 1 : 0;
            m_b1   = (d < 0) ? 1 : 0;
            m_any1 = m_b1;
            ev     = (m_b1 != 0);
        end
        m_ov1 = v1 ? 1 : 0;
        if (c1) m_cnt1 = 0;
        else if (ev) m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : 65535;

        ev = 1'b0;
        if (v4) begin
            m_y4 = 0;
            bsum = 0;
            for (int i = 0; i < 4; i++) begin
                d = int'(a4[i]) - int'(b4[i]);
                if (d != 0) m_y4 += (1 << i);
                if (d < 0)  bsum += (1 << i);
            end
            m_b4   = bsum;
            m_any4 = (bsum != 0) ? 1 : 0;
            ev     = (bsum != 0);
        end
        m_ov4 = v4 ? 1 : 0;
        if (c4) m_cnt4 = 0;
        else if (ev) m_cnt4 = (m_cnt4 < 3) ? m_cnt4 + 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        check("u1.y",          32'(y1),   32'(m_y1));
        check("u1.borrow",     32'(bo1),  32'(m_b1));
        check("u1.out_valid",  32'(ov1),  32'(m_ov1));
        check("u1.any_borrow", 32'(any1), 32'(m_any1));
        check("u1.borrow_cnt", 32'(cnt1), 32'(m_cnt1));
        check("u4.y",          32'(y4),   32'(m_y4));
        check("u4.borrow",     32'(bo4),  32'(m_b4));
        check("u4.out_valid",  32'(ov4),  32'(m_ov4));
        check("u4.any_borrow", 32'(any4), 32'(m_any4));
        check("u4.borrow_cnt", 32'(cnt4), 32'(m_cnt4));
    endtask

    // Advance one clock; inputs were set 1 time unit after the previous edge.
    task automatic clk_step();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int saved_cnt;
        tt[0] = '{a: 1'b0, b: 1'b0, y: 1'b0, bo: 1'b0};
        tt[1] = '{a: 1'b0, b: 1'b1, y: 1'b1, bo: 1'b1};
        tt[2] = '{a: 1'b1, b: 1'b0, y: 1'b1, bo: 1'b0};
        tt[3] = '{a: 1'b1, b: 1'b1, y: 1'b0, bo: 1'b0};

        rst_n = 1'b0;
        a1 = 0; b1 = 0; v1 = 0; c1 = 0;
        a4 = 0; b4 = 0; v4 = 0; c4 = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Truth table on the single-lane instance.
        for (int i = 0; i < 4; i++) begin
            a1 = tt[i].a; b1 = tt[i].b; v1 = 1'b1;
            clk_step();
            check("tt.y",         32'(y1),  32'(tt[i].y));
            check("tt.borrow",    32'(bo1), 32'(tt[i].bo));
            check("tt.out_valid", 32'(ov1), 32'd1);
        end
        v1 = 1'b0;

        // Lane independence on the 4-lane instance.
        a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
        clk_step();
        check("lanes.y",      32'(y4),   32'h6);
        check("lanes.borrow", 32'(bo4),  32'h2);
        check("lanes.any",    32'(any4), 32'd1);
        a4 = 4'hF; b4 = 4'h0;
        clk_step();
        check("lanes.borrow0", 32'(bo4),  32'h0);
        check("lanes.any0",    32'(any4), 32'd0);
        v4 = 1'b0;

        // Valid gating: idle cycle with borrowing and unknown inputs changes nothing.
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
        clk_step();
        saved_cnt = m_cnt1;
        a1 = 1'b0; b1 = 1'b1; v1 = 1'b0;
        clk_step();
        check("gate.out_valid", 32'(ov1),  32'd0);
        check("gate.y",         32'(y1),   32'd1);
        check("gate.borrow",    32'(bo1),  32'd0);
        check("gate.cnt",       32'(cnt1), 32'(saved_cnt));
        a1 = 1'bx; b1 = 1'bx;
        clk_step();
        a1 = 1'b0; b1 = 1'b0;

        // Counter: three events, then clear beats a simultaneous event.
        c1 = 1'b1;
        clk_step();
        check("cnt.clr", 32'(cnt1), 32'd0);
        c1 = 1'b0; a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
        repeat (3) clk_step();
        check("cnt.three", 32'(cnt1), 32'd3);
        c1 = 1'b1;
        clk_step();
        check("cnt.clr_prio", 32'(cnt1), 32'd0);
        c1 = 1'b0; v1 = 1'b0;

        // Saturation with a 2-bit counter.
        c4 = 1'b1;
        clk_step();
        c4 = 1'b0; a4 = 4'h0; b4 = 4'h1; v4 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            clk_step();
            check("sat.cnt", 32'(cnt4), 32'((k < 3) ? k : 3));
        end
        v4 = 1'b0;

        // Asynchronous reset mid-cycle with nonzero outputs.
        a4 = 4'h0; b4 = 4'hF; v4 = 1'b1; a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
        clk_step();
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst.y4",    32'(y4),   32'd0);
        check("rst.bo4",   32'(bo4),  32'd0);
        check("rst.ov4",   32'(ov4),  32'd0);
        check("rst.any4",  32'(any4), 32'd0);
        check("rst.cnt4",  32'(cnt4), 32'd0);
        check("rst.cnt1",  32'(cnt1), 32'd0);
        check("rst.ov1",   32'(ov1),  32'd0);
        clk_step();
        v1 = 1'b0; v4 = 1'b0;
        rst_n = 1'b1;
        clk_step();
        check("release.ov4", 32'(ov4), 32'd0);
        v1 = 1'b1; v4 = 1'b1;
        clk_step();
        check("release.cap", 32'(ov4), 32'd1);

        // Random traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            v1 = ($urandom_range(0, 3) != 0); c1 = ($urandom_range(0, 15) == 0);
            a4 = 4'($urandom); b4 = 4'($urandom);
            v4 = ($urandom_range(0, 3) != 0); c4 = ($urandom_range(0, 7) == 0);
            clk_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
